// File: rtl/run_length_reporter_if.sv
// Record stream from run_length_reporter: show-ahead head record with a
// valid/ready handshake.
interface run_length_reporter_if #(
  parameter int LEN_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [LEN_W-1:0] out_len;
  logic             out_sat;

  modport master (output out_valid, out_len, out_sat, input out_ready);
  modport slave  (input out_valid, out_len, out_sat, output out_ready);
endinterface

// File: rtl/run_length_reporter.sv
// Measures the length of each high run on det and queues one {sat,len} record
// per completed run in a show-ahead FIFO; counts runs and flags dropped records.
module run_length_reporter #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   det,
  input  logic                   clr_ovf,
  output logic [CNT_W-1:0]       run_count,
  output logic                   overflow,
  run_length_reporter_if.master  rpt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic             sat;
    logic [LEN_W-1:0] len;
  } rec_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] len, len_next;
  logic             sat, sat_next;
  logic             complete;

  rec_t             mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop, push, drop;
  rec_t             head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_next;
      len   <= len_next;
      sat   <= sat_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    len_next   = len;
    sat_next   = sat;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (en && det) begin
          state_next = RUN;
          len_next   = LEN_W'(1);
          sat_next   = 1'b0;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
          len_next   = '0;
        end else if (det) begin
          if (len != LEN_MAX) len_next = len + 1'b1;
          else                sat_next = 1'b1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
          len_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && rpt.out_ready;
  assign push  = complete && (!full || pop);
  assign drop  = complete && full && !pop;

  // NOTE: the record storage has no reset; the pointers alone define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{sat: sat, len: len};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (complete) run_count <= run_count + 1'b1;
      // A drop outranks a simultaneous clear.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign rpt.out_valid = !empty;
  assign rpt.out_len   = empty ? '0 : head.len;
  assign rpt.out_sat   = empty ? 1'b0 : head.sat;

endmodule

// File: tb/tb_run_length_reporter.sv
// Self-checking bench for run_length_reporter: vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_run_length_reporter;

  localparam int LEN_W = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int LMAX  = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, det, clr_ovf;
  logic [CNT_W-1:0] run_count;
  logic             overflow;

  run_length_reporter_if #(.LEN_W(LEN_W)) rif ();

  run_length_reporter #(.LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .det       (det),
    .clr_ovf   (clr_ovf),
    .run_count (run_count),
    .overflow  (overflow),
    .rpt       (rif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is an integer count of consecutive ones, records
  // live in a bounded queue.
  typedef struct {int len; bit sat;} mrec_t;
  mrec_t mq[$];
  bit    m_active;
  int    m_len;
  int    m_cnt;
  bit    m_ovf;

  task automatic model_step(input logic e, d, r, c, x);
    bit    done, was_full, popped;
    mrec_t rec;
    if (x) begin
      mq.delete();
      m_active = 0; m_len = 0; m_cnt = 0; m_ovf = 0;
      return;
    end
    done = 0;
    if (m_active) begin
      if (!e)     m_active = 0;
      else if (d) m_len++;
      else begin done = 1; m_active = 0; end
    end else if (e && d) begin
      m_active = 1; m_len = 1;
    end
    was_full = (mq.size() == DEPTH);
    popped   = (mq.size() > 0) && r;
    if (popped) void'(mq.pop_front());
    if (done) begin
      m_cnt++;
      if (was_full && !popped) m_ovf = 1;
      else begin
        rec.len = (m_len > LMAX) ? LMAX : m_len;
        rec.sat = (m_len > LMAX);
        mq.push_back(rec);
      end
    end
    if (c && !(done && was_full && !popped)) m_ovf = 0;
  endtask

  task automatic cycle(input logic e, d, r, c, x);
    en = e; det = d; rif.out_ready = r; clr_ovf = c; rst = x;
    @(posedge clk);
    model_step(e, d, r, c, x);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, rif.out_valid, mq.size() > 0);
    check({tag, ".len"},   rif.out_len,   mq.size() > 0 ? mq[0].len : 0);
    check({tag, ".sat"},   rif.out_sat,   mq.size() > 0 ? mq[0].sat : 0);
    check({tag, ".count"}, run_count,     m_cnt % (1 << CNT_W));
    check({tag, ".ovf"},   overflow,      m_ovf);
  endtask

  task automatic run_of(input int n, input logic r_body, r_end, c_end);
    for (int i = 0; i < n; i++) cycle(1, 1, r_body, 0, 0);
    cycle(1, 0, r_end, c_end, 0);
  endtask

  task automatic drain_one(input string tag, input int exp_len);
    check({tag, ".valid"}, rif.out_valid, 1);
    check({tag, ".len"},   rif.out_len,   exp_len);
    cycle(0, 0, 1, 0, 0);
  endtask

  typedef struct {
    logic rst, en, det, rdy, clr;
    logic valid; int len; logic sat; int cnt; logic ovf;
  } vec_t;
  vec_t tbl[8];

  initial begin
    rst = 1; en = 0; det = 0; clr_ovf = 0; rif.out_ready = 0;

    // Basic run of 3 with a ready consumer; rows give outputs after each edge.
    tbl[0] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 1, 0,  0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 1, 1, 0,  0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 1, 0,  0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 0, 1, 0,  1, 3, 0, 1, 0};
    tbl[5] = '{0, 1, 0, 1, 0,  0, 0, 0, 1, 0};
    tbl[6] = '{0, 0, 1, 1, 0,  0, 0, 0, 1, 0};
    tbl[7] = '{0, 0, 0, 1, 1,  0, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].en, tbl[i].det, tbl[i].rdy, tbl[i].clr, tbl[i].rst);
      check($sformatf("vec%0d.valid", i), rif.out_valid, tbl[i].valid);
      check($sformatf("vec%0d.len", i),   rif.out_len,   tbl[i].len);
      check($sformatf("vec%0d.sat", i),   rif.out_sat,   tbl[i].sat);
      check($sformatf("vec%0d.count", i), run_count,     tbl[i].cnt);
      check($sformatf("vec%0d.ovf", i),   overflow,      tbl[i].ovf);
    end

    // Overflow: five runs into a four-deep FIFO with no consumer.
    cycle(0, 0, 0, 0, 1);
    for (int l = 1; l <= 5; l++) run_of(l, 0, 0, 0);
    check("ovf5.ovf", overflow, 1);
    check("ovf5.count", run_count, 5);
    for (int l = 1; l <= 4; l++) drain_one($sformatf("ovf_drain%0d", l), l);
    check("ovf_drain.empty", rif.out_valid, 0);

    // Saturation: 300 ones.
    cycle(0, 0, 0, 0, 1);
    run_of(300, 0, 0, 0);
    check("sat.len", rif.out_len, LMAX);
    check("sat.sat", rif.out_sat, 1);
    check("sat.count", run_count, 1);

    // Full FIFO with a pop on the completion edge: no drop, order kept.
    cycle(0, 0, 0, 0, 1);
    for (int l = 1; l <= 4; l++) run_of(l, 0, 0, 0);
    run_of(5, 0, 1, 0);
    check("fullpop.ovf", overflow, 0);
    for (int l = 2; l <= 5; l++) drain_one($sformatf("fullpop_drain%0d", l), l);
    check("fullpop.empty", rif.out_valid, 0);

    // Abort: en dropped on the third high cycle.
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("abort.valid", rif.out_valid, 0);
    check("abort.count", run_count, 0);
    run_of(2, 0, 0, 0);
    check("abort_rerun.len", rif.out_len, 2);

    // Reset mid-run with queued records and overflow set.
    cycle(0, 0, 0, 0, 1);
    for (int l = 1; l <= 5; l++) run_of(l, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 1);
    check("midrst.valid", rif.out_valid, 0);
    check("midrst.count", run_count, 0);
    check("midrst.ovf", overflow, 0);

    // Drop coincident with clr_ovf keeps overflow; a later clear clears it.
    for (int l = 1; l <= 4; l++) run_of(l, 0, 0, 0);
    run_of(2, 0, 0, 1);
    check("dropclr.ovf", overflow, 1);
    cycle(0, 0, 0, 1, 0);
    check("clr.ovf", overflow, 0);

    // Randomized traffic against the reference model.
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 499) == 0);
      compare_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_length_reporter.md
# run_length_reporter

Downstream consumer of the consecutive-ones sequence detector. Its `det` input is driven by the detector's registered output. The block measures the length, in clock cycles, of each high run on `det` and queues one record per completed run in a small show-ahead FIFO, drained over a valid/ready handshake. It also keeps a running count of completed runs and a sticky overflow flag for records dropped because the FIFO was full.

## Interface
- `LEN_W`, default 8: run-length field width; the length saturates at 2^LEN_W−1.
- `DEPTH`, default 4: FIFO depth in records; power of two, ≥2.
- `CNT_W`, default 16: width of the completed-run counter.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `en`, in, 1: measurement enable.
- `det`, in, 1: detector output, sampled every cycle.
- `out_valid`, out, 1: FIFO non-empty.
- `out_ready`, in, 1: consumer accepts the head record.
- `out_len`, out, LEN_W: head record length; 0 when empty.
- `out_sat`, out, 1: head record saturated; 0 when empty.
- `run_count`, out, CNT_W: completed runs, modulo 2^CNT_W.
- `overflow`, out, 1: sticky; a record was dropped.
- `clr_ovf`, in, 1: clears `overflow`.

## Operation
- Reset values: state IDLE, length counter 0, FIFO empty, `out_valid`=0, `out_len`=0, `out_sat`=0, `run_count`=0, `overflow`=0.
- FSM, two states:
  - IDLE: if `en`=1 and `det`=1, go to RUN with len=1, sat=0. Otherwise stay.
  - RUN, `en`=0: abort. Go to IDLE; no record; `run_count` unchanged.
  - RUN, `en`=1, `det`=1: len+1 if len<2^LEN_W−1; otherwise hold len and set sat=1.
  - RUN, `en`=1, `det`=0: complete. Push {sat,len}, increment `run_count`, go to IDLE.
- Back-to-back runs (1,0,1): the completion cycle returns to IDLE, and the next `det`=1 starts a new run. No cycle is lost beyond the separating zero.
- FIFO:
  - Show-ahead: the head record is on `out_len`/`out_sat` whenever `out_valid`=1.
  - Pop when `out_valid`&`out_ready`.
  - Push when not full, or when full with a pop in the same cycle. Order is preserved.
- Full with no pop at completion: the record is dropped, `overflow`←1, and `run_count` still increments.
- `clr_ovf` clears `overflow`. A drop in the same cycle as `clr_ovf` wins, so `overflow` stays 1.
- `out_ready` while empty has no effect.
- Pointer wrap: pointers are log2(DEPTH)+1 bits. Full means MSBs differ and LSBs are equal.

## Timing
- Let cycle k be the edge that samples the first `det`=1. A run of L ones ends at the edge sampling `det`=0 at k+L.
- At that edge the record is written and `run_count` updates. `out_valid`=1 is visible immediately after the edge, so latency from the falling `det` sample is 1 edge.
- A pop at edge t presents the next head after t. The FIFO can sustain one push and one pop per cycle.
- `rst` mid-run or with a non-empty FIFO: after the reset edge, all outputs take their reset values, and in-flight and queued records are discarded.
- `en` only gates run start and abort. FIFO draining continues while `en`=0.

## Test plan
- Reset, `en`=1, `det` high 3 cycles then low, `out_ready`=1:
  - one cycle after the det-low edge: `out_valid`=1, `out_len`=3, `out_sat`=0, `run_count`=1;
  - `out_valid`=0 after the pop.
- `out_ready`=0, DEPTH=4, runs of lengths 1,2,3,4,5 each separated by one zero:
  - `overflow`=1 after the 5th run, `run_count`=5;
  - draining yields 1,2,3,4, then `out_valid`=0.
- LEN_W=8, `det` high 300 cycles: record `out_len`=255, `out_sat`=1, `run_count`=1.
- FIFO full, with `out_ready`=1 on the same edge a run completes:
  - no overflow;
  - drain order is old records then the new one.
- Abort: `det` high 4 cycles, `en` dropped on the 3rd: no record, `run_count`=0. Then `en`=1 with a 2-cycle run gives `out_len`=2.
- Reset mid-run with 2 queued records: next cycle `out_valid`=0, `run_count`=0, `overflow`=0. A drop coincident with `clr_ovf` leaves `overflow`=1.
